byte_mem_req_ctrl: RTL and testbench

Request front-end for the team's byte-masked 32-bit memory. It accepts read and write requests on a valid/ready interface and buffers them in a small FIFO. Each request is issued to the memory as a single-cycle `enb` pulse with registered address, data and mask. Read data returned by the memory is captured into a response register with valid/ready backpressure. The block sits directly upstream of the memory and owns all of its control inputs.

---
 rtl/byte_mem_req_ctrl_if.sv | 34 +++
 rtl/byte_mem_req_ctrl.sv | 164 ++++++++++++++++
 tb/tb_byte_mem_req_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/byte_mem_req_ctrl_if.sv
// Request/issue/response bundle for byte_mem_req_ctrl.
// master: requester side (also the memory's read-data return).
// slave : byte_mem_req_ctrl itself.
interface byte_mem_req_ctrl_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [3:0]        req_mask;

  logic              mem_enb;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data, req_mask, rsp_ready, mem_rdata,
    input  req_ready, mem_enb, mem_wr, mem_addr, mem_data, mem_mask, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, req_mask, rsp_ready, mem_rdata,
    output req_ready, mem_enb, mem_wr, mem_addr, mem_data, mem_mask, rsp_valid, rsp_data
  );
endinterface

// File: rtl/byte_mem_req_ctrl.sv
// Request front-end for the byte-masked 32-bit memory: request FIFO,
// single-cycle registered issue strobe, registered read-response slot.
// Optional feature macro: BYTE_MEM_ZERO_MASK_DROP_EN (zero-mask writes are
// popped without strobing the memory or counting in wr_cnt).
module byte_mem_req_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  byte_mem_req_ctrl_if.slave     bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            wr_cnt
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        mask;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RSP_HOLD} state_e;

  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  state_e            state_q, state_d;
  logic              mem_enb_q, mem_enb_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;

  logic   req_ready, push, pop, drop, issue, rsp_accept, read_ok;
  entry_t head;

  assign req_ready  = (count_q < CW'(DEPTH));
  assign push       = bus.req_valid && req_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign rsp_accept = rsp_valid_q && bus.rsp_ready;
  // A read may go out when nothing is outstanding, or on the edge the
  // pending response is accepted (back-to-back reads).
  assign read_ok    = (state_q == IDLE) || (state_q == ISSUE) ||
                      ((state_q == RSP_HOLD) && rsp_accept);
  assign pop        = (count_q != '0) && (head.wr || read_ok);
`ifdef BYTE_MEM_ZERO_MASK_DROP_EN
  assign drop       = pop && head.wr && (head.mask == 4'b0000);
`else
  assign drop       = 1'b0;
`endif
  assign issue      = pop && !drop;

  // FIFO storage and pointer/occupancy update
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{wr: bus.req_wr, addr: bus.req_addr,
                           data: bus.req_data, mask: bus.req_mask};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FSM next state, issue registers, response slot and write counter
  always_comb begin
    state_d     = state_q;
    mem_enb_d   = issue;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_mask_d  = mem_mask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    wr_cnt_d    = wr_cnt_q;
    if (issue) begin
      mem_wr_d   = head.wr;
      mem_addr_d = head.addr;
      mem_data_d = head.data;
      mem_mask_d = head.mask;
      if (head.wr && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
    end
    case (state_q)
      IDLE, ISSUE: begin
        if (pop && !head.wr)       state_d = RD_WAIT;
        else if (count_d != '0)    state_d = ISSUE;
        else                       state_d = IDLE;
      end
      // RD_WAIT covers the strobe cycle and the data cycle; the strobe cycle
      // is the only one in RD_WAIT where the registered issue is a read.
      RD_WAIT: begin
        if (!(mem_enb_q && !mem_wr_q)) begin
          state_d     = RSP_HOLD;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.mem_rdata;
        end
      end
      RSP_HOLD: begin
        if (rsp_accept) begin
          rsp_valid_d = 1'b0;
          if (pop && !head.wr)     state_d = RD_WAIT;
          else if (count_d != '0)  state_d = ISSUE;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage needs no reset; occupancy gates every read of it
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      mem_enb_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_mask_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_cnt_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_enb_q   <= mem_enb_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_mask_q  <= mem_mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mem_enb   = mem_enb_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_mask  = mem_mask_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign fifo_count    = count_q;
  assign wr_cnt        = wr_cnt_q;
endmodule

// File: tb/tb_byte_mem_req_ctrl.sv
// Directed bench for byte_mem_req_ctrl with a byte-masked memory model.
module tb_byte_mem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  fifo_count;
  logic [15:0] wr_cnt;
  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] mem_model [8] = '{default: '0};

  byte_mem_req_ctrl_if #(.ADDR_W(3)) bus();

  byte_mem_req_ctrl #(.ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .fifo_count(fifo_count), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous byte-masked memory; read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.mem_enb) begin
      if (bus.mem_wr) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_mask[i]) mem_model[bus.mem_addr][8*i +: 8] <= bus.mem_data[8*i +: 8];
      end else begin
        bus.mem_rdata <= mem_model[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_mask  = m;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_req_ready"},  32'(bus.req_ready), 32'd1);
    chk({p, "_mem_enb"},    32'(bus.mem_enb),   32'd0);
    chk({p, "_mem_wr"},     32'(bus.mem_wr),    32'd0);
    chk({p, "_mem_addr"},   32'(bus.mem_addr),  32'd0);
    chk({p, "_mem_data"},   bus.mem_data,       32'd0);
    chk({p, "_mem_mask"},   32'(bus.mem_mask),  32'd0);
    chk({p, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
    chk({p, "_rsp_data"},   bus.rsp_data,       32'd0);
    chk({p, "_fifo_count"}, 32'(fifo_count),    32'd0);
    chk({p, "_wr_cnt"},     32'(wr_cnt),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_mask  = '0;
    bus.rsp_ready = 1'b0;
    #12;
    check_reset("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Single write
    push(1'b1, 3'd5, 32'hA1B2C3D4, 4'b0101);
    chk("wr_k_enb", 32'(bus.mem_enb), 32'd0);
    chk("wr_k_count", 32'(fifo_count), 32'd1);
    tick();
    chk("wr_enb", 32'(bus.mem_enb), 32'd1);
    chk("wr_wr", 32'(bus.mem_wr), 32'd1);
    chk("wr_addr", 32'(bus.mem_addr), 32'd5);
    chk("wr_data", bus.mem_data, 32'hA1B2C3D4);
    chk("wr_mask", 32'(bus.mem_mask), 32'b0101);
    chk("wr_cnt1", 32'(wr_cnt), 32'd1);
    chk("wr_count0", 32'(fifo_count), 32'd0);
    tick();
    chk("wr_enb_drop", 32'(bus.mem_enb), 32'd0);

    // Read with backpressure
    push(1'b0, 3'd5, 32'h0, 4'hF);
    chk("rd_k_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rd_enb", 32'(bus.mem_enb), 32'd1);
    chk("rd_wr", 32'(bus.mem_wr), 32'd0);
    chk("rd_addr", 32'(bus.mem_addr), 32'd5);
    tick();
    chk("rd_k2_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rd_k3_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_k3_data", bus.rsp_data, 32'h00B200D4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_hold_data", bus.rsp_data, 32'h00B200D4);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("rd_accepted", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;

    // Ordering: read A, write B, read C with A's response held
    push(1'b0, 3'd5, 32'h0, 4'hF);
    tick();
    tick();
    tick();
    chk("ord_a_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ord_a_data", bus.rsp_data, 32'h00B200D4);
    push(1'b1, 3'd1, 32'h11111111, 4'hF);
    push(1'b0, 3'd1, 32'h0, 4'hF);
    chk("ord_b_enb", 32'(bus.mem_enb), 32'd1);
    chk("ord_b_wr", 32'(bus.mem_wr), 32'd1);
    chk("ord_b_addr", 32'(bus.mem_addr), 32'd1);
    chk("ord_b_hold", 32'(bus.rsp_valid), 32'd1);
    tick();
    tick();
    chk("ord_c_stall_enb", 32'(bus.mem_enb), 32'd0);
    chk("ord_c_stall_cnt", 32'(fifo_count), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("ord_c_enb", 32'(bus.mem_enb), 32'd1);
    chk("ord_c_wr", 32'(bus.mem_wr), 32'd0);
    chk("ord_c_addr", 32'(bus.mem_addr), 32'd1);
    chk("ord_a_gone", 32'(bus.rsp_valid), 32'd0);
    chk("ord_count", 32'(fifo_count), 32'd0);
    tick();
    chk("ord_c_wait", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("ord_c_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ord_c_data", bus.rsp_data, 32'h11111111);
    chk("ord_wr_cnt", 32'(wr_cnt), 32'd2);

    // Full FIFO behind a blocked read (C's response still held)
    push(1'b0, 3'd5, 32'h0, 4'hF);
    push(1'b1, 3'd2, 32'h22222222, 4'hF);
    push(1'b1, 3'd3, 32'h33333333, 4'hF);
    push(1'b1, 3'd4, 32'h44444444, 4'hF);
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    push(1'b1, 3'd6, 32'h66666666, 4'hF);
    chk("full_reject", 32'(fifo_count), 32'd4);
    chk("full_no_enb", 32'(bus.mem_enb), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("full_ready_up", 32'(bus.req_ready), 32'd1);
    chk("full_pop_count", 32'(fifo_count), 32'd3);
    chk("full_d_enb", 32'(bus.mem_enb), 32'd1);
    chk("full_d_wr", 32'(bus.mem_wr), 32'd0);
    chk("full_d_addr", 32'(bus.mem_addr), 32'd5);
    tick();
    chk("full_w2_wr", 32'(bus.mem_wr), 32'd1);
    chk("full_w2_addr", 32'(bus.mem_addr), 32'd2);
    tick();
    chk("full_d_valid", 32'(bus.rsp_valid), 32'd1);
    chk("full_d_data", bus.rsp_data, 32'h00B200D4);
    chk("full_w3_addr", 32'(bus.mem_addr), 32'd3);
    tick();
    chk("full_w4_addr", 32'(bus.mem_addr), 32'd4);
    chk("full_d_taken", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("full_idle_enb", 32'(bus.mem_enb), 32'd0);
    chk("full_empty", 32'(fifo_count), 32'd0);
    chk("full_wr_cnt", 32'(wr_cnt), 32'd5);
    bus.rsp_ready = 1'b0;

    // Zero-mask write
    push(1'b1, 3'd6, 32'hFFFFFFFF, 4'b0000);
    tick();
`ifdef BYTE_MEM_ZERO_MASK_DROP_EN
    chk("zm_enb", 32'(bus.mem_enb), 32'd0);
    chk("zm_wr_cnt", 32'(wr_cnt), 32'd5);
`else
    chk("zm_enb", 32'(bus.mem_enb), 32'd1);
    chk("zm_mask", 32'(bus.mem_mask), 32'd0);
    chk("zm_wr_cnt", 32'(wr_cnt), 32'd6);
`endif
    chk("zm_count", 32'(fifo_count), 32'd0);
    tick();
    chk("zm_enb_low", 32'(bus.mem_enb), 32'd0);

    // Reset with a read in RD_WAIT and three entries queued
    push(1'b0, 3'd0, 32'h0, 4'hF);
    tick();
    tick();
    push(1'b0, 3'd5, 32'h0, 4'hF);
    push(1'b1, 3'd7, 32'h77777777, 4'hF);
    push(1'b1, 3'd7, 32'h77777777, 4'hF);
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_count", 32'(fifo_count), 32'd3);
    chk("mid_x_enb", 32'(bus.mem_enb), 32'd1);
    chk("mid_x_wr", 32'(bus.mem_wr), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("mid_no_enb", 32'(bus.mem_enb), 32'd0);
    end
    chk("mid_mem7", mem_model[7], 32'd0);
    chk("mid_mem5", mem_model[5], 32'h00B200D4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
